// File: rtl/bus_cmd_pkg.sv
// rtl/bus_cmd_pkg.sv - shared types and helpers for the bus command issuer
//
// Purpose : FSM state encoding, counter widths and the packed command-entry
//           width helper used by the issuer top and its command FIFO.
// Ports   : none (package).

package bus_cmd_pkg;

    // Issuer FSM: IDLE waits for a queued command, ISSUE drives one on the bus.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Completed-command counter width (wraps naturally at 2**16).
    localparam int DONE_W = 16;

    // Wait counter width; large enough for the biggest legal TIMEOUT (65535).
    localparam int WAIT_W = 16;

    // Width of one packed FIFO entry laid out as {write, addr, data, ch}.
    function automatic int cmd_width(input int addr_w, input int data_w, input int ch_w);
        return 1 + addr_w + data_w + ch_w;
    endfunction

endpackage

// File: rtl/bus_cmd_issuer_if.sv
// rtl/bus_cmd_issuer_if.sv - command-side and bus-side signal bundle
//
// Purpose : groups the command handshake and the issued bus command so the
//           issuer and its environment connect through one port.
// Ports   : command side cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_data/cmd_ch;
//           bus side addr/valid(channel tag)/data/wen/ren/ready;
//           status err (timeout drop pulse) and done_cnt (completed commands).
//           Modport slave is the issuer, modport master is its environment.

interface bus_cmd_issuer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int NUM_CH = 8
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [CH_W-1:0]   cmd_ch;

    logic [ADDR_W-1:0] addr;
    logic [CH_W-1:0]   valid;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              ren;
    logic              ready;

    logic              err;
    logic [15:0]       done_cnt;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_ch, ready,
        output cmd_ready, addr, valid, data, wen, ren, err, done_cnt
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_ch, ready,
        input  cmd_ready, addr, valid, data, wen, ren, err, done_cnt
    );

endinterface

// File: rtl/bus_cmd_fifo.sv
// rtl/bus_cmd_fifo.sv - synchronous command FIFO with head and next-entry peek
//
// Purpose : holds packed commands in arrival order. The head entry stays in
//           the FIFO while it is being issued and leaves only on pop.
// Ports   : clk, reset (sync, active-high)
//           push, push_data   - write side; ignored while full
//           pop               - drop the head entry; ignored while empty
//           head, next_head   - entries at the read pointer and one behind it
//           full, empty       - occupancy flags
//           has_next          - at least two entries stored (next_head valid)

module bus_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] next_head,
    output logic             full,
    output logic             empty,
    output logic             has_next
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic do_push;
    logic do_pop;

    // A full FIFO refuses a push even if the same cycle pops.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign has_next = (count >= CNT_W'(2));

    // Head comes straight out of the storage registers; the peek one slot
    // behind lets the issuer chain commands without an idle cycle.
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_cmd_issuer.sv
// rtl/bus_cmd_issuer.sv - queued read/write command issuer with ready timeout
//
// Purpose : accepts commands into a FIFO and issues them one at a time as
//           registered bus strobes. A command retires when ready is seen
//           (done_cnt increments) or is dropped after TIMEOUT wait cycles
//           (err pulses for one cycle). Back-to-back commands issue with no
//           idle cycle between them.
// Ports   : clk   - sole clock, rising edge
//           reset - synchronous, active-high
//           bus   - bus_cmd_issuer_if.slave: command handshake in, bus
//                   command out, err / done_cnt status out

module bus_cmd_issuer
    import bus_cmd_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int NUM_CH  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    bus_cmd_issuer_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CMD_W = cmd_width(ADDR_W, DATA_W, CH_W);

    state_t state;
    state_t state_nx;

    logic [CMD_W-1:0] push_entry;
    logic [CMD_W-1:0] head;
    logic [CMD_W-1:0] next_head;
    logic [CMD_W-1:0] sel_entry;
    logic             full;
    logic             empty;
    logic             has_next;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [CH_W-1:0]   sel_ch;

    logic              pop;
    logic              load_head;
    logic              load_next;
    logic              go_idle;
    logic              complete;
    logic              timeout;

    logic [ADDR_W-1:0] addr_r;
    logic [CH_W-1:0]   ch_r;
    logic [DATA_W-1:0] data_r;
    logic              wen_r;
    logic              ren_r;
    logic              err_r;
    logic [DONE_W-1:0] done_cnt_r;
    logic [WAIT_W-1:0] wait_cnt;

    assign push_entry = {bus.cmd_write, bus.cmd_addr, bus.cmd_data, bus.cmd_ch};

    bus_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.cmd_valid),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .full      (full),
        .empty     (empty),
        .has_next  (has_next)
    );

    // ready only matters while a command is on the bus (state ISSUE); ready
    // on the last wait cycle counts as a completion, never as a timeout.
    assign complete = (state == ISSUE) && bus.ready;
    assign timeout  = (state == ISSUE) && !bus.ready && (wait_cnt == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        load_head = 1'b0;
        load_next = 1'b0;
        go_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx  = ISSUE;
                    load_head = 1'b1;
                end
            end
            ISSUE: begin
                if (complete || timeout) begin
                    pop = 1'b1;
                    // The active command is still the FIFO head, so the one
                    // to chain into is the entry behind it.
                    if (has_next) begin
                        load_next = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        go_idle  = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign sel_entry = load_next ? next_head : head;
    assign {sel_write, sel_addr, sel_data, sel_ch} = sel_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r     <= '0;
            ch_r       <= '0;
            data_r     <= '0;
            wen_r      <= 1'b0;
            ren_r      <= 1'b0;
            err_r      <= 1'b0;
            done_cnt_r <= '0;
            wait_cnt   <= '0;
        end else begin
            err_r <= timeout;
            if (complete) begin
                done_cnt_r <= done_cnt_r + DONE_W'(1);
            end
            if (load_head || load_next) begin
                addr_r   <= sel_addr;
                ch_r     <= sel_ch;
                data_r   <= sel_write ? sel_data : '0;
                wen_r    <= sel_write;
                ren_r    <= !sel_write;
                wait_cnt <= '0;
            end else if (go_idle) begin
                addr_r   <= '0;
                ch_r     <= '0;
                data_r   <= '0;
                wen_r    <= 1'b0;
                ren_r    <= 1'b0;
                wait_cnt <= '0;
            end else if (state == ISSUE) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.addr      = addr_r;
    assign bus.valid     = ch_r;
    assign bus.data      = data_r;
    assign bus.wen       = wen_r;
    assign bus.ren       = ren_r;
    assign bus.err       = err_r;
    assign bus.done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_bus_cmd_issuer.sv
// tb/tb_bus_cmd_issuer.sv - directed self-checking bench for bus_cmd_issuer

module tb_bus_cmd_issuer;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int NUM_CH  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 3;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [63:0] wdata [4];

    bus_cmd_issuer_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) bus ();

    bus_cmd_issuer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_CH  (NUM_CH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [2:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_ch    = c;
    endtask

    task automatic idle_cmd();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_ch    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bus.ready = 1'b0;
        idle_cmd();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        wdata[0] = 64'h0123_4567_89AB_CDEF;
        wdata[1] = 64'hFEDC_BA98_7654_3210;
        wdata[2] = 64'h0000_0000_0000_0001;
        wdata[3] = 64'hFFFF_FFFF_FFFF_FFFF;

        // Reset state, sampled while reset is still high.
        reset     = 1'b1;
        bus.ready = 1'b0;
        idle_cmd();
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst_wen",       64'(bus.wen),       64'(0));
        chk("rst_ren",       64'(bus.ren),       64'(0));
        chk("rst_err",       64'(bus.err),       64'(0));
        chk("rst_addr",      64'(bus.addr),      64'(0));
        chk("rst_valid",     64'(bus.valid),     64'(0));
        chk("rst_data",      64'(bus.data),      64'(0));
        chk("rst_done",      64'(bus.done_cnt),  64'(0));
        reset = 1'b0;

        // Single read, ready high: two-cycle latency, one ren cycle.
        bus.ready = 1'b1;
        drive_cmd(1'b0, 32'h1000, 64'hDEAD_BEEF, 3'd3);
        @(negedge clk);
        idle_cmd();
        chk("t1_lat_ren", 64'(bus.ren), 64'(0));
        @(negedge clk);
        chk("t1_ren",   64'(bus.ren),   64'(1));
        chk("t1_wen",   64'(bus.wen),   64'(0));
        chk("t1_addr",  64'(bus.addr),  64'h1000);
        chk("t1_valid", 64'(bus.valid), 64'(3));
        chk("t1_data",  64'(bus.data),  64'(0));
        @(negedge clk);
        chk("t1_ren_off", 64'(bus.ren),      64'(0));
        chk("t1_done",    64'(bus.done_cnt), 64'(1));

        // Four back-to-back writes, ready high: no bubble, push order.
        do_reset();
        bus.ready = 1'b1;
        drive_cmd(1'b1, 32'h200, wdata[0], 3'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t2_wen%0d", k), 64'(bus.wen), 64'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) begin
                chk($sformatf("t2_data%0d", k), bus.data, wdata[k-1]);
                chk($sformatf("t2_addr%0d", k), 64'(bus.addr), 64'(32'h200 + 32'(4 * (k - 1))));
            end
            if (k < 3) drive_cmd(1'b1, 32'h200 + 32'(4 * (k + 1)), wdata[k+1], 3'd1);
            else idle_cmd();
        end
        chk("t2_done", 64'(bus.done_cnt), 64'(4));

        // Timeout: ready low, wen held TIMEOUT+1 cycles, err pulse, next issues.
        do_reset();
        drive_cmd(1'b1, 32'h2000, 64'hAAAA, 3'd2);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("t3_wen%0d", k), 64'(bus.wen), 64'(k >= 1 && k <= 5));
            chk($sformatf("t3_err%0d", k), 64'(bus.err), 64'(k == 5));
            if (k >= 1 && k <= 4) chk($sformatf("t3_addr%0d", k), 64'(bus.addr), 64'h2000);
            if (k == 5) begin
                chk("t3_next_addr", 64'(bus.addr),     64'h3000);
                chk("t3_done_keep", 64'(bus.done_cnt), 64'(0));
                bus.ready = 1'b1;
            end
            if (k == 0) drive_cmd(1'b1, 32'h3000, 64'hBBBB, 3'd4);
            else idle_cmd();
        end
        chk("t3_done", 64'(bus.done_cnt), 64'(1));

        // Ready arriving on the last wait cycle completes, no error.
        do_reset();
        drive_cmd(1'b0, 32'h4000, 64'h0, 3'd5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle_cmd();
            chk($sformatf("t4_ren%0d", k), 64'(bus.ren), 64'(k >= 1 && k <= 4));
            if (k == 4) bus.ready = 1'b1;
        end
        chk("t4_err",  64'(bus.err),      64'(0));
        chk("t4_done", 64'(bus.done_cnt), 64'(1));

        // Fill the FIFO with ready low; the fifth push is dropped.
        do_reset();
        drive_cmd(1'b1, 32'h10, 64'h10, 3'd0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("t5_cmd_ready%0d", k), 64'(bus.cmd_ready), 64'(k != 3 && k != 4));
            chk($sformatf("t5_wen%0d", k), 64'(bus.wen), 64'(k >= 1 && k <= 7));
            chk($sformatf("t5_err%0d", k), 64'(bus.err), 64'(0));
            if (k >= 1 && k <= 7)
                chk($sformatf("t5_addr%0d", k), 64'(bus.addr), 64'((k <= 4) ? 16 : 16 * (k - 3)));
            if (k < 4) begin
                drive_cmd(1'b1, 32'(16 * (k + 2)), 64'(k + 2), 3'd0);
            end else begin
                idle_cmd();
                bus.ready = 1'b1;
            end
        end
        chk("t5_done", 64'(bus.done_cnt), 64'(4));

        // Reset while ren is high with three entries queued.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_cmd(1'b0, 32'h500 + 32'(16 * k), 64'h0, 3'd6);
            @(negedge clk);
        end
        idle_cmd();
        chk("t6_ren_before", 64'(bus.ren), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("t6_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("t6_ren",       64'(bus.ren),       64'(0));
        chk("t6_wen",       64'(bus.wen),       64'(0));
        chk("t6_err",       64'(bus.err),       64'(0));
        chk("t6_addr",      64'(bus.addr),      64'(0));
        chk("t6_valid",     64'(bus.valid),     64'(0));
        chk("t6_done",      64'(bus.done_cnt),  64'(0));
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t6_post_ren%0d", k), 64'(bus.ren), 64'(0));
            chk($sformatf("t6_post_err%0d", k), 64'(bus.err), 64'(0));
        end

        // done_cnt wraps from 65535 to 0 on one completion.
        do_reset();
        force dut.done_cnt_r = 16'hFFFF;
        #1;
        release dut.done_cnt_r;
        bus.ready = 1'b1;
        drive_cmd(1'b1, 32'h6000, 64'h1234, 3'd7);
        @(negedge clk);
        idle_cmd();
        @(negedge clk);
        chk("t7_wen",     64'(bus.wen),      64'(1));
        chk("t7_preload", 64'(bus.done_cnt), 64'hFFFF);
        @(negedge clk);
        chk("t7_wrap",    64'(bus.done_cnt), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_cmd_issuer.md
BUS_CMD_ISSUER -- requirements
Module: bus_cmd_issuer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the bus address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning the bus write-data width.
REQ-003 The block SHALL have parameter NUM_CH, default 8, meaning the channel count; legal range is 2 or more.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries; legal values are powers of two, 2 or more.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum wait cycles for ready; legal range is 1 to 65535.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 cmd_valid  input  1  command offered.
REQ-010 cmd_ready  output  1  command accepted this cycle when cmd_valid is also high.
REQ-011 cmd_write  input  1  1 = write command, 0 = read command.
REQ-012 cmd_addr  input  ADDR_W  command address.
REQ-013 cmd_data  input  DATA_W  write data; ignored for reads.
REQ-014 cmd_ch  input  $clog2(NUM_CH)  channel tag.
REQ-015 addr  output  ADDR_W  bus address.
REQ-016 valid  output  $clog2(NUM_CH)  channel tag of the active bus command.
REQ-017 data  output  DATA_W  bus write data; driven to 0 on reads.
REQ-018 wen  output  1  write strobe.
REQ-019 ren  output  1  read strobe.
REQ-020 ready  input  1  bus completes the active command.
REQ-021 err  output  1  one-cycle pulse when a command is dropped on timeout.
REQ-022 done_cnt  output  16  count of completed commands; wraps at 65535 to 0.

Function
REQ-023 cmd_ready SHALL equal !full; a push on the same cycle as a pop from a full FIFO SHALL NOT be accepted.
REQ-024 The FIFO SHALL store {write, addr, data, ch} in order, so commands issue strictly in FIFO order.
REQ-025 The FSM SHALL have exactly two states, IDLE and ISSUE.
REQ-026 In IDLE with the FIFO non-empty, the FSM SHALL move to ISSUE and load the head entry into the registered bus outputs.
REQ-027 Minimum latency SHALL be 2 cycles: a push accepted at edge N SHALL produce wen or ren high from the cycle after edge N+1.
REQ-028 In ISSUE, exactly one of wen/ren SHALL be high, and addr, valid and data SHALL stay stable until completion or timeout.
REQ-029 Completion SHALL occur at the edge where (wen|ren) && ready; at that edge the FIFO SHALL pop and done_cnt SHALL increment.
REQ-030 On completion with another entry available, the FSM SHALL stay in ISSUE and present the next command with no bubble; otherwise it SHALL go to IDLE with wen=ren=0.
REQ-031 A wait counter SHALL clear on entry to each command; when it reaches TIMEOUT with ready still low, the block SHALL pop the entry, pulse err for 1 cycle, leave done_cnt unchanged, and proceed as in REQ-030.
REQ-032 When ready is high on the TIMEOUT cycle, the result SHALL be a completion, not an error.
REQ-033 ready SHALL be ignored while wen=ren=0.

Reset
REQ-034 While reset is high, the FIFO SHALL be emptied (cmd_ready=1) and the FSM SHALL be in IDLE.
REQ-035 While reset is high, addr, valid, data, wen, ren, err and done_cnt SHALL all be 0.
REQ-036 Reset asserted mid-command SHALL abandon the command without an err pulse, and no FIFO entry SHALL survive reset.

Structure
REQ-037 Package bus_cmd_pkg SHALL hold the state enum (IDLE, ISSUE) and the parametrised command struct width helper.
REQ-038 Sub-module bus_cmd_fifo SHALL be a synchronous FIFO with full/empty flags and a registered head.

Verification
REQ-039 Push one read (addr 0x1000, ch 3) with ready tied high -> ren high for exactly 1 cycle with addr=0x1000 and valid=3, then done_cnt=1.
REQ-040 Push 4 writes back-to-back with ready high -> 4 consecutive wen cycles with no bubble, data in push order, done_cnt=4.
REQ-041 Hold ready low with TIMEOUT=3 -> wen held for 4 cycles, one err pulse, done_cnt unchanged, next command issues.
REQ-042 Fill the FIFO with ready low -> cmd_ready=0 after 4 pushes; a fifth push while full is dropped.
REQ-043 Assert reset while ren is high with 3 entries queued -> the next cycle shows all outputs 0, cmd_ready=1, and no err pulse.
REQ-044 Preload done_cnt to 65535 and complete one command -> done_cnt wraps to 0.
